tor_slot_sched: RTL and testbench

TOR_SLOT_SCHED -- requirements
Module: tor_slot_sched

---
 rtl/tor_slot_sched_pkg.sv | 19 +
 rtl/tor_slot_sched_if.sv | 27 ++
 rtl/tor_port_rr_arb.sv | 124 ++++++++++++
 rtl/tor_slot_sched.sv | 97 +++++++++
 tb/tb_tor_slot_sched.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tor_slot_sched_pkg.sv
// Shared types and constants for the ToR slot scheduler.
package tor_slot_sched_pkg;

    // Per-port transmit FSM: waiting for a grantable request, or serving one packet.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } port_state_e;

    localparam int LEN_W = 16;

    // Head-packet length, in clock cycles.
    typedef logic [LEN_W-1:0] len_t;

    // Target ring encoding carried on i_req_dir.
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/tor_slot_sched_if.sv
// Requester-side bus of the slot scheduler: requests, packet info, and the two ring grants.
interface tor_slot_sched_if
    import tor_slot_sched_pkg::*;
#(
    parameter int P_CHANNEL_NUM = 4
);

    logic [P_CHANNEL_NUM-1:0]       i_req;
    logic [P_CHANNEL_NUM-1:0]       i_req_dir;
    logic [LEN_W*P_CHANNEL_NUM-1:0] i_req_len;
    logic [P_CHANNEL_NUM-1:0]       i_eop;
    logic [P_CHANNEL_NUM-1:0]       o_grant_down;
    logic [P_CHANNEL_NUM-1:0]       o_grant_up;

    // Requester queues drive the packet information and receive grants.
    modport master (
        output i_req, i_req_dir, i_req_len, i_eop,
        input  o_grant_down, o_grant_up
    );

    // The scheduler samples the packet information and drives grants.
    modport slave (
        input  i_req, i_req_dir, i_req_len, i_eop,
        output o_grant_down, o_grant_up
    );

endinterface

// File: rtl/tor_port_rr_arb.sv
// Round-robin arbiter plus IDLE/BUSY grant FSM for one ring TX port.
// A requester is granted only if its whole packet fits before the slot ends
// and it starts no earlier than the end of the guard window.
module tor_port_rr_arb
    import tor_slot_sched_pkg::*;
#(
    parameter int   P_CHANNEL_NUM  = 4,
    parameter int   P_SLOT_CYCLES  = 1024,
    parameter int   P_GUARD_CYCLES = 16,
    parameter logic P_DIR          = DIR_DOWN
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_en,
    input  logic                           i_wrap,
    input  logic [15:0]                    i_cnt,
    input  logic [P_CHANNEL_NUM-1:0]       i_req,
    input  logic [P_CHANNEL_NUM-1:0]       i_req_dir,
    input  logic [LEN_W*P_CHANNEL_NUM-1:0] i_req_len,
    input  logic [P_CHANNEL_NUM-1:0]       i_eop,
    output logic [P_CHANNEL_NUM-1:0]       o_grant,
    output logic                           o_overrun
);

    localparam int              PTR_W     = (P_CHANNEL_NUM > 1) ? $clog2(P_CHANNEL_NUM) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(P_CHANNEL_NUM - 1);
    localparam logic [17:0]     SLOT_LIM  = 18'(P_SLOT_CYCLES);
    localparam logic [17:0]     GUARD_LIM = 18'(P_GUARD_CYCLES);

    port_state_e              state_q, state_d;
    logic [P_CHANNEL_NUM-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic                     overrun_q, overrun_d;

    logic [P_CHANNEL_NUM-1:0] elig;
    logic [PTR_W-1:0]         cand;
    logic [PTR_W-1:0]         pick_idx;
    logic                     pick_vld;
    logic [17:0]              next_k;
    logic                     eop_hit;

    // A grant issued now starts transmitting on cycle cnt+1.
    assign next_k  = {2'b00, i_cnt} + 18'd1;
    assign eop_hit = |(i_eop & grant_q);

    // Per-requester eligibility: pending, aimed at this ring, non-empty, clear of guard, fits the slot.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        elig = '0;
        for (int r = 0; r < P_CHANNEL_NUM; r++) begin
            elig[r] = i_en && i_req[r] && (i_req_dir[r] == P_DIR)
                   && (i_req_len[LEN_W*r +: LEN_W] != '0)
                   && (next_k >= GUARD_LIM)
                   && ((next_k + 18'(i_req_len[LEN_W*r +: LEN_W])) <= SLOT_LIM);
        end
    end

    // First eligible requester at or after the round-robin pointer.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < P_CHANNEL_NUM; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % P_CHANNEL_NUM);
            if (!pick_vld && elig[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Next-state logic: grant on a pick, release on the owner's eop, force-revoke at slot wrap.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    ptr_d             = (pick_idx == LAST_IDX) ? '0 : pick_idx + PTR_W'(1);
                    state_d           = BUSY;
                end
            end
            BUSY: begin
                // The owner's eop wins over the slot wrap, so a packet ending exactly on time is not an overrun.
                if (eop_hit) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (i_wrap) begin
                    grant_d   = '0;
                    state_d   = IDLE;
                    overrun_d = 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, grant, pointer and overrun registers.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_overrun = overrun_q;

endmodule

// File: rtl/tor_slot_sched.sv
// Time-slotted scheduler for a ToR switch with a down-ring and an up-ring TX port.
// Owns the slot counter and slot id; each ring port has its own arbiter/FSM.
module tor_slot_sched
    import tor_slot_sched_pkg::*;
#(
    parameter int P_CHANNEL_NUM  = 4,
    parameter int P_SLOT_CYCLES  = 1024,
    parameter int P_GUARD_CYCLES = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    tor_slot_sched_if.slave        bus,
    output logic                   o_slot_start,
    output logic                   o_guard,
    output logic [7:0]             o_slot_id,
    output logic                   o_overrun
);

    localparam logic [15:0] CNT_LAST  = 16'(P_SLOT_CYCLES - 1);
    localparam logic [15:0] GUARD_END = 16'(P_GUARD_CYCLES);

    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  slot_id_q, slot_id_d;
    logic        wrap;
    logic        overrun_down, overrun_up;

    assign wrap = i_en && (cnt_q == CNT_LAST);

    // Slot counter and slot id advance only while enabled.
    always_comb begin
        cnt_d     = cnt_q;
        slot_id_d = slot_id_q;
        if (i_en) begin
            cnt_d = wrap ? '0 : cnt_q + 16'd1;
        end
        if (wrap) begin
            slot_id_d = slot_id_q + 8'd1;
        end
    end

    // Slot counter and slot id registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            slot_id_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            slot_id_q <= slot_id_d;
        end
    end

    // Slot start is also qualified by reset so it stays low while reset is held at cnt 0.
    assign o_slot_start = i_rst_n && i_en && (cnt_q == '0);
    assign o_guard      = (cnt_q < GUARD_END);
    assign o_slot_id    = slot_id_q;
    assign o_overrun    = overrun_down | overrun_up;

    tor_port_rr_arb #(
        .P_CHANNEL_NUM  (P_CHANNEL_NUM),
        .P_SLOT_CYCLES  (P_SLOT_CYCLES),
        .P_GUARD_CYCLES (P_GUARD_CYCLES),
        .P_DIR          (DIR_DOWN)
    ) u_arb_down (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_wrap    (wrap),
        .i_cnt     (cnt_q),
        .i_req     (bus.i_req),
        .i_req_dir (bus.i_req_dir),
        .i_req_len (bus.i_req_len),
        .i_eop     (bus.i_eop),
        .o_grant   (bus.o_grant_down),
        .o_overrun (overrun_down)
    );

    tor_port_rr_arb #(
        .P_CHANNEL_NUM  (P_CHANNEL_NUM),
        .P_SLOT_CYCLES  (P_SLOT_CYCLES),
        .P_GUARD_CYCLES (P_GUARD_CYCLES),
        .P_DIR          (DIR_UP)
    ) u_arb_up (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_wrap    (wrap),
        .i_cnt     (cnt_q),
        .i_req     (bus.i_req),
        .i_req_dir (bus.i_req_dir),
        .i_req_len (bus.i_req_len),
        .i_eop     (bus.i_eop),
        .o_grant   (bus.o_grant_up),
        .o_overrun (overrun_up)
    );

endmodule

// File: tb/tb_tor_slot_sched.sv
// Directed bench for tor_slot_sched with a 64-cycle slot and 4-cycle guard.
module tb_tor_slot_sched;
    import tor_slot_sched_pkg::*;

    localparam int N     = 4;
    localparam int SLOT  = 64;
    localparam int GUARD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       slot_start;
    logic       guard;
    logic [7:0] slot_id;
    logic       overrun;

    int         n_checks = 0;
    int         n_errors = 0;

    // Reference slot counter / slot id.
    int         m_cnt = 0;
    logic [7:0] m_slot_id = '0;
    logic       mon_on = 1'b0;

    tor_slot_sched_if #(.P_CHANNEL_NUM(N)) bus_if ();

    tor_slot_sched #(
        .P_CHANNEL_NUM  (N),
        .P_SLOT_CYCLES  (SLOT),
        .P_GUARD_CYCLES (GUARD)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .bus          (bus_if),
        .o_slot_start (slot_start),
        .o_guard      (guard),
        .o_slot_id    (slot_id),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt     <= 0;
            m_slot_id <= '0;
        end else if (en) begin
            m_cnt <= (m_cnt == SLOT - 1) ? 0 : m_cnt + 1;
            if (m_cnt == SLOT - 1) m_slot_id <= m_slot_id + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Slot timing outputs against the reference counter on every falling edge.
    always @(negedge clk) begin
        if (mon_on) begin
            check("mon_guard", 32'(guard), 32'(m_cnt < GUARD));
            check("mon_slot_start", 32'(slot_start), 32'(m_cnt == 0 && en && rst_n));
            check("mon_slot_id", 32'(slot_id), 32'(m_slot_id));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int k);
        int n = 0;
        while (m_cnt != k && n < 300) begin
            next_cyc();
            n++;
        end
        if (m_cnt != k) check("wait_cnt_timeout", 32'(m_cnt), 32'(k));
    endtask

    task automatic set_req(input int r, input logic dir, input logic [15:0] len);
        bus_if.i_req[r]               = 1'b1;
        bus_if.i_req_dir[r]           = dir;
        bus_if.i_req_len[16*r +: 16]  = len;
    endtask

    task automatic clear_all();
        bus_if.i_req     = '0;
        bus_if.i_req_dir = '0;
        bus_if.i_req_len = '0;
        bus_if.i_eop     = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant_down"}, 32'(bus_if.o_grant_down), 32'h0);
        check({tag, "_grant_up"}, 32'(bus_if.o_grant_up), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
        check({tag, "_guard"}, 32'(guard), 32'h1);
        check({tag, "_slot_start"}, 32'(slot_start), 32'h0);
        check({tag, "_slot_id"}, 32'(slot_id), 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        clear_all();
        next_cyc();
        next_cyc();
        rst_n = 1'b1;
        en    = 1'b1;
        #1;
        check("rst_release_slot_start", 32'(slot_start), 32'h1);
    endtask

    initial begin
        logic [3:0] exp;
        logic [7:0] sid;
        int         ph;
        int         idx;

        rst_n = 1'b1;
        en    = 1'b1;
        clear_all();
        #2 rst_n = 1'b0;
        #1;
        // Reset with enable high: slot_start must still be low.
        check_reset_outputs("init");
        mon_on = 1'b1;
        next_cyc();
        next_cyc();

        // Release with enable low: counter holds, no slot start.
        en    = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            check("en_low_slot_start", 32'(slot_start), 32'h0);
            check("en_low_guard", 32'(guard), 32'h1);
        end
        en = 1'b1;
        #1;
        check("first_slot_start", 32'(slot_start), 32'h1);

        // Single requester from cnt 0: grant first at cnt 4, drop one cycle after eop.
        set_req(0, DIR_DOWN, 16'd10);
        for (int c = 1; c <= 13; c++) begin
            next_cyc();
            check("s1_grant_down", 32'(bus_if.o_grant_down), (c >= 4) ? 32'h1 : 32'h0);
            if (c == 13) begin
                bus_if.i_eop[0] = 1'b1;
                bus_if.i_req[0] = 1'b0;
            end
        end
        next_cyc();
        bus_if.i_eop = '0;
        check("s1_release", 32'(bus_if.o_grant_down), 32'h0);
        check("s1_no_overrun", 32'(overrun), 32'h0);

        // Four requesters, len 5: grants 0,1,2,3,0 with a one-cycle gap.
        do_reset();
        for (int r = 0; r < N; r++) set_req(r, DIR_DOWN, 16'd5);
        for (int c = 1; c <= 33; c++) begin
            next_cyc();
            exp = 4'h0;
            ph  = 5;
            if (c >= 4) begin
                ph  = (c - 4) % 6;
                idx = (c - 4) / 6;
                if (ph < 5) exp = 4'(1 << (idx % 4));
            end
            check("s2_grant_down", 32'(bus_if.o_grant_down), 32'(exp));
            check("s2_grant_up", 32'(bus_if.o_grant_up), 32'h0);
            bus_if.i_eop = (ph == 4) ? exp : 4'h0;
            if (c == 32) bus_if.i_req = '0;
        end
        clear_all();

        // Too long to fit at cnt 50: waits for the next slot, granted at cnt 4.
        wait_cnt(50);
        set_req(2, DIR_DOWN, 16'd20);
        for (int s = 1; s <= 18; s++) begin
            next_cyc();
            check("s3_grant_down", 32'(bus_if.o_grant_down), (m_cnt == 4) ? 32'h4 : 32'h0);
        end
        wait_cnt(23);
        check("s3_hold", 32'(bus_if.o_grant_down), 32'h4);
        bus_if.i_eop[2] = 1'b1;
        bus_if.i_req[2] = 1'b0;
        next_cyc();
        bus_if.i_eop = '0;
        check("s3_release", 32'(bus_if.o_grant_down), 32'h0);

        // Zero-length requester is never granted.
        set_req(1, DIR_DOWN, 16'd0);
        for (int s = 0; s < 8; s++) begin
            next_cyc();
            check("len0_grant_down", 32'(bus_if.o_grant_down), 32'h0);
        end
        clear_all();

        // Withheld eop: revoked at wrap with one overrun pulse; foreign eop and req drop ignored.
        wait_cnt(0);
        sid = m_slot_id;
        set_req(1, DIR_DOWN, 16'd10);
        wait_cnt(4);
        check("s4_grant", 32'(bus_if.o_grant_down), 32'h2);
        bus_if.i_req[1] = 1'b0;
        wait_cnt(20);
        bus_if.i_eop[0] = 1'b1;
        next_cyc();
        bus_if.i_eop = '0;
        check("s4_foreign_eop", 32'(bus_if.o_grant_down), 32'h2);
        wait_cnt(63);
        check("s4_hold_end", 32'(bus_if.o_grant_down), 32'h2);
        check("s4_no_early_overrun", 32'(overrun), 32'h0);
        next_cyc();
        check("s4_revoked", 32'(bus_if.o_grant_down), 32'h0);
        check("s4_overrun", 32'(overrun), 32'h1);
        check("s4_slot_id", 32'(slot_id), 32'(8'(sid + 8'd1)));
        next_cyc();
        check("s4_overrun_pulse", 32'(overrun), 32'h0);
        check("s4_no_regrant", 32'(bus_if.o_grant_down), 32'h0);

        // Down and up ports grant independently on the same cycle.
        wait_cnt(10);
        set_req(0, DIR_DOWN, 16'd6);
        set_req(3, DIR_UP, 16'd6);
        next_cyc();
        check("s5_grant_down", 32'(bus_if.o_grant_down), 32'h1);
        check("s5_grant_up", 32'(bus_if.o_grant_up), 32'h8);
        wait_cnt(16);
        bus_if.i_eop = 4'b1001;
        bus_if.i_req = '0;
        next_cyc();
        bus_if.i_eop = '0;
        check("s5_release_down", 32'(bus_if.o_grant_down), 32'h0);
        check("s5_release_up", 32'(bus_if.o_grant_up), 32'h0);

        // Enable low: busy port keeps its grant until eop, idle port issues nothing.
        wait_cnt(20);
        set_req(0, DIR_DOWN, 16'd8);
        next_cyc();
        check("s6_grant_down", 32'(bus_if.o_grant_down), 32'h1);
        en = 1'b0;
        set_req(2, DIR_UP, 16'd5);
        for (int s = 0; s < 4; s++) begin
            next_cyc();
            check("s6_hold_down", 32'(bus_if.o_grant_down), 32'h1);
            check("s6_no_up", 32'(bus_if.o_grant_up), 32'h0);
        end
        bus_if.i_eop[0] = 1'b1;
        bus_if.i_req[0] = 1'b0;
        next_cyc();
        bus_if.i_eop = '0;
        check("s6_release_down", 32'(bus_if.o_grant_down), 32'h0);
        check("s6_still_no_up", 32'(bus_if.o_grant_up), 32'h0);
        clear_all();
        en = 1'b1;

        // Reset mid-grant at cnt 30: everything clears at once, no overrun.
        wait_cnt(25);
        set_req(0, DIR_DOWN, 16'd20);
        wait_cnt(30);
        check("s7_grant", 32'(bus_if.o_grant_down), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("s7_async");
        clear_all();
        next_cyc();
        check("s7_overrun_held", 32'(overrun), 32'h0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();
        check("s7_after_release", 32'(bus_if.o_grant_down), 32'h0);
        check("s7_after_overrun", 32'(overrun), 32'h0);

        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
